// File: rtl/image_load_sequencer.sv
// image_load_sequencer: walks LEN chunks of LANES consecutive pixels starting at BASE, drives
// the combinational-read data memory address, registers each returned vector (masking lanes
// that fall past the last pixel of the image) and hands chunks downstream on valid/ready.
// Optional feature: define LOAD_PERF_CNT_EN to add stall_cnt_o, a saturating count of
// backpressure cycles during a run.
module image_load_sequencer #(
  parameter int unsigned ImageWidth  = 96,
  parameter int unsigned ImageHeight = 96,
  parameter int unsigned Lanes       = 8,
  parameter int unsigned AddrW       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [AddrW-1:0]       base_i,
  input  logic [10:0]            len_i,
  input  logic                   abort_i,
  output logic [AddrW-1:0]       mem_addr_o,
  input  logic [15:0][15:0]      mem_rd_i,
  output logic [Lanes-1:0][15:0] out_data_o,
  output logic [10:0]            out_idx_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
`ifdef LOAD_PERF_CNT_EN
  output logic [15:0]            stall_cnt_o,
`endif
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned PixMax = ImageWidth * ImageHeight - 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 state_q;
  logic [AddrW-1:0]       mem_addr_q;
  logic [10:0]            idx_q;
  logic [10:0]            len_q;
  logic [Lanes-1:0][15:0] out_data_q;
  logic [10:0]            out_idx_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic                   done_q;

  logic [Lanes-1:0][15:0] lane_data;
  logic [AddrW:0]         lane_addr [Lanes];
  logic                   capture;
  logic                   last_chunk;
  logic                   start_ok;
  logic                   unused_upper_lanes;

  // Memory lanes beyond Lanes carry nothing of interest.
  assign unused_upper_lanes = ^mem_rd_i[15:Lanes];

  // Zero lanes whose pixel address lies past the image; compared one bit wider so no wrap.
  always_comb begin
    for (int unsigned k = 0; k < Lanes; k++) begin
      lane_addr[k] = {1'b0, mem_addr_q} + (AddrW+1)'(k);
      lane_data[k] = (lane_addr[k] > (AddrW+1)'(PixMax)) ? 16'h0000 : mem_rd_i[k];
    end
  end

  assign capture    = (state_q == StRun) && (!out_valid_q || out_ready_i);
  assign last_chunk = (idx_q == len_q - 11'd1);
  assign start_ok   = (state_q == StIdle) && start_i && !abort_i;

  // Sequencer FSM with all outputs registered; abort overrides every transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort_i) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q <= len_i;
            idx_q <= '0;
            if (len_i != 11'd0) begin
              mem_addr_q <= base_i;
              state_q    <= StRun;
              busy_q     <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (capture) begin
            out_data_q  <= lane_data;
            out_idx_q   <= idx_q;
            out_valid_q <= 1'b1;
            idx_q       <= idx_q + 11'd1;
            // Address stays on the final chunk once it has been fetched.
            if (last_chunk) begin
              state_q <= StDrain;
            end else begin
              mem_addr_q <= mem_addr_q + AddrW'(Lanes);
            end
          end
        end
        StDrain: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef LOAD_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  // Count backpressure cycles of the active run; restart on each accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (start_ok) begin
      stall_cnt_q <= '0;
    end else if (busy_q && out_valid_q && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

  assign mem_addr_o  = mem_addr_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_image_load_sequencer.sv
// Bench for image_load_sequencer: transaction-level model (beat counter per run, chunk contents
// computed from base + i*8 with image-edge masking) checked every cycle, plus directed cases.
module tb_image_load_sequencer;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [15:0]      base_i = '0;
  logic [10:0]      len_i = '0;
  logic             abort_i = 1'b0;
  logic             out_ready_i = 1'b0;
  logic [15:0]      mem_addr_o;
  logic [15:0][15:0] mem_rd_i;
  logic [7:0][15:0] out_data_o;
  logic [10:0]      out_idx_o;
  logic             out_valid_o;
  logic             busy_o;
  logic             done_o;
`ifdef LOAD_PERF_CNT_EN
  logic [15:0]      stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  image_load_sequencer dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .base_i     (base_i),
    .len_i      (len_i),
    .abort_i    (abort_i),
    .mem_addr_o (mem_addr_o),
    .mem_rd_i   (mem_rd_i),
    .out_data_o (out_data_o),
    .out_idx_o  (out_idx_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
`ifdef LOAD_PERF_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ (a << 3) ^ 16'h3C5A;
  endfunction

  // Expected chunk: pixels base+idx*8 .. +7 (address wraps at 2^16), zero past pixel 9215.
  function automatic logic [127:0] exp_chunk(input logic [15:0] b, input int idx);
    logic [127:0] r;
    int start_addr;
    int a;
    r = '0;
    start_addr = (int'(b) + idx * 8) % 65536;
    for (int k = 0; k < 8; k++) begin
      a = start_addr + k;
      if (a <= 9215) r[k*16 +: 16] = mem_val(16'(a));
    end
    return r;
  endfunction

  // Combinational-read memory; upper lanes carry junk the DUT must ignore.
  logic [15:0] junk = 16'h0;
  always @(posedge clk_i) junk <= 16'($urandom);
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      mem_rd_i[k] = (k < 8) ? mem_val(mem_addr_o + 16'(k)) : (junk ^ 16'(k));
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: describes the current cycle.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_done_n;
  logic        m_idle;
  logic [15:0] m_base = '0;
  int          m_len = 0;
  int          m_idx = 0;
  int          beats = 0;
  logic [15:0] m_stall = '0;

  // Compare process: check outputs against the model, then advance it from sampled inputs.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_idx   = 0;
      m_stall = '0;
    end else begin
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      if (!m_busy) begin
        chk("valid_idle", out_valid_o, 1'b0);
      end else if (out_valid_o) begin
        chk("idx", out_idx_o, 128'(m_idx));
        chk("data", out_data_o, exp_chunk(m_base, m_idx));
      end
`ifdef LOAD_PERF_CNT_EN
      chk("stall_cnt", stall_cnt_o, m_stall);
      if (m_busy && out_valid_o && !out_ready_i && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
      m_idle   = !m_busy && !m_done;
      m_done_n = 1'b0;
      if (abort_i) begin
        m_busy = 1'b0;
      end else if (m_idle && start_i) begin
        m_stall = '0;
        if (len_i == 11'd0) begin
          m_done_n = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_base = base_i;
          m_len  = int'(len_i);
          m_idx  = 0;
        end
      end else if (m_busy && out_valid_o && out_ready_i) begin
        m_idx++;
        beats++;
        if (m_idx == m_len) begin
          m_busy   = 1'b0;
          m_done_n = 1'b1;
        end
      end
      m_done = m_done_n;
    end
  end

  // Stimulus always stands 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic go(input logic [15:0] b, input logic [10:0] l);
    start_i = 1'b1;
    base_i  = b;
    len_i   = l;
    cyc();
    start_i = 1'b0;
    base_i  = 16'($urandom);
    len_i   = 11'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy || m_done) && n < budget) begin
      cyc();
      n++;
    end
    chk("run_ends", m_busy || m_done, 1'b0);
  endtask

  int b0;
  int rmode;

  initial begin
    // Reset values while held in reset.
    #3;
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    cyc();
    cyc();

    // Streaming with ready held high: latency, addresses, indices, done timing.
    out_ready_i = 1'b1;
    go(16'd0, 11'd4);
    @(negedge clk_i);
    chk("t2_addr0", mem_addr_o, 0);
    chk("t2_novalid", out_valid_o, 0);
    for (int j = 0; j < 4; j++) begin
      cyc();
      @(negedge clk_i);
      chk("t2_valid", out_valid_o, 1);
      chk("t2_idx", out_idx_o, 128'(j));
      chk("t2_addr", mem_addr_o, (j < 3) ? 128'(8 * (j + 1)) : 128'd24);
      if (j == 0) begin
        chk("t2_lane0", out_data_o[0], mem_val(16'd0));
        chk("t2_lane7", out_data_o[7], mem_val(16'd7));
      end
    end
    cyc();
    @(negedge clk_i);
    chk("t2_done", done_o, 1);
    chk("t2_end_valid", out_valid_o, 0);
    cyc();

    // Backpressure: five stalled cycles on the first chunk.
    go(16'd16, 11'd3);
    cyc();
    out_ready_i = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk_i);
      chk("t3_hold_valid", out_valid_o, 1);
      chk("t3_hold_idx", out_idx_o, 0);
      chk("t3_hold_addr", mem_addr_o, 24);
      cyc();
    end
    out_ready_i = 1'b1;
    wait_idle(50);
`ifdef LOAD_PERF_CNT_EN
    chk("t3_stall_cnt", stall_cnt_o, 5);
`endif

    // Image edge: partial then fully masked chunk.
    go(16'd9210, 11'd2);
    cyc();
    @(negedge clk_i);
    chk("t4_lane0", out_data_o[0], mem_val(16'd9210));
    chk("t4_lane5", out_data_o[5], mem_val(16'd9215));
    chk("t4_lane6", out_data_o[6], 0);
    chk("t4_lane7", out_data_o[7], 0);
    cyc();
    @(negedge clk_i);
    chk("t4_idx1", out_idx_o, 1);
    chk("t4_chunk1", out_data_o, 0);
    chk("t4_addr", mem_addr_o, 9218);
    cyc();
    wait_idle(20);

    // len=0 completes at once; start during a run is ignored.
    go(16'd123, 11'd0);
    @(negedge clk_i);
    chk("t5_done", done_o, 1);
    chk("t5_novalid", out_valid_o, 0);
    cyc();
    @(negedge clk_i);
    chk("t5_done_drop", done_o, 0);
    cyc();
    b0 = beats;
    out_ready_i = 1'b0;
    go(16'd0, 11'd6);
    cyc();
    start_i = 1'b1;
    base_i  = 16'd500;
    len_i   = 11'd1;
    cyc();
    start_i = 1'b0;
    out_ready_i = 1'b1;
    wait_idle(50);
    chk("t5_beats", beats - b0, 6);

    // Abort with chunk 3 on offer and ready high.
    go(16'd0, 11'd10);
    cyc();
    cyc();
    cyc();
    cyc();
    abort_i = 1'b1;
    @(negedge clk_i);
    chk("t6_idx3", out_idx_o, 3);
    cyc();
    abort_i = 1'b0;
    @(negedge clk_i);
    chk("t6_valid", out_valid_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_done", done_o, 0);
    cyc();
    @(negedge clk_i);
    chk("t6_done2", done_o, 0);
    cyc();
    go(16'd64, 11'd2);
    wait_idle(20);

    // Randomized runs: random ready, rare abort and spurious start, edge and wrap bases.
    for (int r = 0; r < 40; r++) begin
      rmode = int'($urandom_range(0, 2));
      if (rmode == 0) base_i = 16'($urandom);
      else if (rmode == 1) base_i = 16'($urandom_range(9100, 9215));
      else base_i = 16'($urandom_range(65500, 65535));
      go(base_i, 11'($urandom_range(0, 24)));
      for (int n = 0; n < 3000 && (m_busy || m_done); n++) begin
        out_ready_i = ($urandom_range(0, 9) < 7);
        abort_i     = ($urandom_range(0, 79) == 0);
        start_i     = ($urandom_range(0, 19) == 0);
        base_i      = 16'($urandom);
        len_i       = 11'($urandom_range(0, 8));
        cyc();
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      out_ready_i = 1'b1;
      wait_idle(100);
      cyc();
    end

    // Reset in the middle of a run.
    go(16'd0, 11'd4);
    cyc();
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("t1_addr", mem_addr_o, 0);
    chk("t1_data", out_data_o, 0);
    chk("t1_idx", out_idx_o, 0);
    chk("t1_valid", out_valid_o, 0);
    chk("t1_busy", busy_o, 0);
    chk("t1_done", done_o, 0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);
      chk("t1_post_done", done_o, 0);
      chk("t1_post_busy", busy_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
